// File: rtl/pc_sequencer.sv
// pc_sequencer: PC/pipeline hazard and redirect controller for the 5-stage core.
// Define HAZARD_PERF_EN to add stall/redirect/load-use performance counters.
module pc_sequencer #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
  parameter int CNT_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      trigger,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_read,
  input  logic                      ex_redirect,
  input  logic [ADDRESS_WIDTH-1:0]  ex_target,
  input  logic                      imem_stall,
  input  logic                      dmem_stall,
  output logic                      pc_stall,
  output logic                      pc_branch,
  output logic [ADDRESS_WIDTH-1:0]  pc_target,
  output logic                      if_id_stall,
  output logic                      if_id_flush,
  output logic                      id_ex_stall,
  output logic                      id_ex_flush,
  output logic                      ex_mem_stall,
  output logic [1:0]                seq_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]      perf_stall_cycles,
  output logic [CNT_WIDTH-1:0]      perf_redirects,
  output logic [CNT_WIDTH-1:0]      perf_loaduse
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, FETCH_WAIT, REDIRECT_HELD} state_e;
  state_e state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] held_q, held_d;
  logic use_ex, load_use;
  assign load_use = ex_mem_read && ex_rd != '0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
  assign pc_target = use_ex ? ex_target : held_q;
  assign seq_state = state_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      held_q  <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      held_q  <= held_d;
    end
  end
  always_comb begin
    state_d = state_q;
    held_d = held_q;
    use_ex = 1'b0;
    pc_stall = 1'b0;
    pc_branch = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_stall = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_stall = 1'b0;
    if (!trigger || state_q == IDLE) begin
      pc_stall = 1'b1;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d = trigger ? RUN : IDLE;
    end else if (dmem_stall) begin
      pc_stall = 1'b1;
      if_id_stall = 1'b1;
      id_ex_stall = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      pc_stall = imem_stall;
      pc_branch = !imem_stall;
      use_ex = !imem_stall;
      held_d = imem_stall ? ex_target : held_q;
      state_d = imem_stall ? REDIRECT_HELD : RUN;
    end else if (state_q == REDIRECT_HELD) begin
      // held redirect is released the first cycle the fetch completes
      if_id_flush = 1'b1;
      pc_stall = imem_stall;
      pc_branch = !imem_stall;
      state_d = imem_stall ? REDIRECT_HELD : RUN;
    end else if (load_use) begin
      pc_stall = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
      state_d = imem_stall ? FETCH_WAIT : RUN;
    end else begin
      pc_stall = imem_stall;
      if_id_flush = imem_stall;
      state_d = imem_stall ? FETCH_WAIT : RUN;
    end
  end
`ifdef HAZARD_PERF_EN
  // if_id_stall together with id_ex_flush only occurs for a load-use bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_redirects    <= '0;
      perf_loaduse      <= '0;
    end else begin
      perf_stall_cycles <= perf_stall_cycles + CNT_WIDTH'(pc_stall && trigger);
      perf_redirects    <= perf_redirects + CNT_WIDTH'(pc_branch);
      perf_loaduse      <= perf_loaduse + CNT_WIDTH'(if_id_stall && id_ex_flush);
    end
  end
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;
  logic clk = 1'b0, rst, trigger, ex_mem_read, ex_redirect, imem_stall, dmem_stall;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic [31:0] ex_target, pc_target;
  logic pc_stall, pc_branch, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
  logic [1:0] seq_state;
  int checks = 0, errors = 0;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles, perf_redirects, perf_loaduse;
`endif
  always #5 clk = ~clk;
  pc_sequencer dut (
    .clk(clk), .rst(rst), .trigger(trigger), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect), .ex_target(ex_target),
    .imem_stall(imem_stall), .dmem_stall(dmem_stall), .pc_stall(pc_stall), .pc_branch(pc_branch),
    .pc_target(pc_target), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .seq_state(seq_state)
`ifdef HAZARD_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_redirects(perf_redirects),
    .perf_loaduse(perf_loaduse)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic settle;
    #1;
  endtask
  initial begin
    rst = 1; trigger = 0; ex_mem_read = 0; ex_redirect = 0; imem_stall = 0; dmem_stall = 0;
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; ex_target = 0;
    tick; tick;
    rst = 0; settle;
    chk("rst_state", 32'(seq_state), 0);
    chk("rst_pc_stall", 32'(pc_stall), 1);
    chk("rst_if_id_flush", 32'(if_id_flush), 1);
    chk("rst_id_ex_flush", 32'(id_ex_flush), 1);
    chk("rst_pc_branch", 32'(pc_branch), 0);
    chk("rst_target", pc_target, 32'hBFC00000);
    trigger = 1; settle;
    chk("idle_trig_state", 32'(seq_state), 0);
    tick;
    chk("run_state", 32'(seq_state), 1);
    chk("run_pc_stall", 32'(pc_stall), 0);
    chk("run_if_id_flush", 32'(if_id_flush), 0);
    // load-use on rs2
    ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; settle;
    chk("lu_pc_stall", 32'(pc_stall), 1);
    chk("lu_if_id_stall", 32'(if_id_stall), 1);
    chk("lu_id_ex_flush", 32'(id_ex_flush), 1);
    chk("lu_if_id_flush", 32'(if_id_flush), 0);
    tick;
    chk("lu_state", 32'(seq_state), 1);
    ex_rd = 0; id_rs2 = 0; settle;
    chk("lu_x0_pc_stall", 32'(pc_stall), 0);
    chk("lu_x0_if_id_stall", 32'(if_id_stall), 0);
    ex_mem_read = 0; tick;
    // redirect in RUN
    ex_redirect = 1; ex_target = 32'h80; settle;
    chk("rd_pc_branch", 32'(pc_branch), 1);
    chk("rd_target", pc_target, 32'h80);
    chk("rd_if_id_flush", 32'(if_id_flush), 1);
    chk("rd_id_ex_flush", 32'(id_ex_flush), 1);
    chk("rd_pc_stall", 32'(pc_stall), 0);
    tick;
    chk("rd_state", 32'(seq_state), 1);
    ex_redirect = 0;
`ifdef HAZARD_PERF_EN
    settle;
    chk("perf_loaduse", perf_loaduse, 1);
    chk("perf_redirects", perf_redirects, 1);
`endif
    // redirect during outstanding fetch
    imem_stall = 1; ex_redirect = 1; ex_target = 32'h100; settle;
    chk("hold_c1_branch", 32'(pc_branch), 0);
    chk("hold_c1_pc_stall", 32'(pc_stall), 1);
    chk("hold_c1_id_ex_flush", 32'(id_ex_flush), 1);
    tick;
    ex_redirect = 0; settle;
    chk("hold_c2_state", 32'(seq_state), 3);
    chk("hold_c2_branch", 32'(pc_branch), 0);
    chk("hold_c2_pc_stall", 32'(pc_stall), 1);
    tick;
    chk("hold_c3_state", 32'(seq_state), 3);
    chk("hold_c3_branch", 32'(pc_branch), 0);
    tick;
    imem_stall = 0; settle;
    chk("hold_c4_branch", 32'(pc_branch), 1);
    chk("hold_c4_target", pc_target, 32'h100);
    chk("hold_c4_if_id_flush", 32'(if_id_flush), 1);
    chk("hold_c4_id_ex_flush", 32'(id_ex_flush), 0);
    tick;
    chk("hold_done_state", 32'(seq_state), 1);
    // plain fetch wait
    imem_stall = 1; settle;
    chk("fw_pc_stall", 32'(pc_stall), 1);
    chk("fw_if_id_flush", 32'(if_id_flush), 1);
    chk("fw_id_ex_flush", 32'(id_ex_flush), 0);
    tick;
    chk("fw_state", 32'(seq_state), 2);
    imem_stall = 0; settle;
    chk("fw_release_stall", 32'(pc_stall), 0);
    tick;
    chk("fw_release_state", 32'(seq_state), 1);
    // latest held redirect wins
    imem_stall = 1; ex_redirect = 1; ex_target = 32'h200; tick;
    ex_target = 32'h300; tick;
    chk("latest_state", 32'(seq_state), 3);
    ex_redirect = 0; imem_stall = 0; settle;
    chk("latest_branch", 32'(pc_branch), 1);
    chk("latest_target", pc_target, 32'h300);
    tick;
    // dmem stall freezes and defers redirect
    dmem_stall = 1; ex_redirect = 1; ex_target = 32'h44; settle;
    chk("dm_pc_stall", 32'(pc_stall), 1);
    chk("dm_if_id_stall", 32'(if_id_stall), 1);
    chk("dm_id_ex_stall", 32'(id_ex_stall), 1);
    chk("dm_ex_mem_stall", 32'(ex_mem_stall), 1);
    chk("dm_branch", 32'(pc_branch), 0);
    chk("dm_if_id_flush", 32'(if_id_flush), 0);
    tick;
    chk("dm_state", 32'(seq_state), 1);
    dmem_stall = 0; settle;
    chk("dm_release_branch", 32'(pc_branch), 1);
    chk("dm_release_target", pc_target, 32'h44);
    tick;
    ex_redirect = 0;
    // trigger drop discards held redirect
    imem_stall = 1; ex_redirect = 1; ex_target = 32'h500; tick;
    ex_redirect = 0; trigger = 0; settle;
    chk("drop_branch", 32'(pc_branch), 0);
    chk("drop_pc_stall", 32'(pc_stall), 1);
    tick;
    chk("drop_state", 32'(seq_state), 0);
    chk("drop_target", pc_target, 32'h500);
    imem_stall = 0; settle;
    chk("drop_idle_branch", 32'(pc_branch), 0);
    trigger = 1; tick;
    chk("rerun_state", 32'(seq_state), 1);
    chk("rerun_branch", 32'(pc_branch), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
